// File: rtl/data_mem_resp.sv
// -----------------------------------------------------------------------------
// data_mem_resp
//   Data-memory responder for a single-cycle core's load/store port.
//   Stores are committed at the rising clock edge with byte/half/word lane
//   enables. Loads are combinational, same cycle, with sign or zero extension.
//   Misaligned or out-of-range accesses set a sticky error flag. An illegal
//   store is dropped and an illegal load returns 0.
//
//   Optional feature macro: DATA_MEM_MMIO_EN
//     When defined, the page 0xFFFF_FF00..0xFFFF_FF0F is active:
//       +0x0 CYCLE  free-running counter. SW loads 0; SB/SH fault.
//       +0x4 GPIO   read/write register that drives gpio_out.
//       +0x8/+0xC   reserved: reads return 0 and stores are ignored.
//     When undefined, the page is out of range and gpio_out is 0.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (clears RAM, err, gpio, counter)
//   addr       byte address
//   wdata      store data, right-aligned
//   MemWrite   00 none, 01 SB, 10 SH, 11 SW
//   SizeLoad   000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, others LW
//   ResultSrc  1 = load this cycle
//   rdata      load result (combinational)
//   err        sticky access-fault flag (registered)
//   err_clr    synchronous clear of err; a fault in the same cycle wins
//   gpio_out   MMIO GPIO register (registered)
// -----------------------------------------------------------------------------
module data_mem_resp #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  MemWrite,
    input  logic [2:0]  SizeLoad,
    input  logic        ResultSrc,
    output logic [31:0] rdata,
    output logic        err,
    input  logic        err_clr,
    output logic [31:0] gpio_out
);

    logic [31:0]   mem_r [DEPTH];
    logic          err_r;
    logic [AW-1:0] word_idx_s;
    logic          in_ram_s;
    logic          in_mmio_s;
    logic          region_ok_s;
    logic          cycle_subword_s;
    logic [31:0]   mmio_rd_s;
    logic [3:0]    wmask_s;
    logic [31:0]   wword_s;
    logic          st_align_ok_s;
    logic          ld_byte_s;
    logic          ld_half_s;
    logic          ld_align_ok_s;
    logic          store_fault_s;
    logic          load_fault_s;
    logic          store_en_s;
    logic [31:0]   raw_s;
    logic [31:0]   shifted_s;
    logic [7:0]    byte_s;
    logic [15:0]   half_s;

    // Any address bit above the word index makes the access out of range.
    assign word_idx_s  = addr[AW+1:2];
    assign in_ram_s    = (addr[31:AW+2] == {(30-AW){1'b0}});
    assign region_ok_s = in_ram_s | in_mmio_s;

    // Store decode: lane mask, replicated store data, and alignment check.
    always_comb begin
        wmask_s       = 4'b0000;
        wword_s       = 32'h0000_0000;
        st_align_ok_s = 1'b1;
        case (MemWrite)
            2'b01: begin
                wmask_s = 4'b0001 << addr[1:0];
                wword_s = {4{wdata[7:0]}};
            end
            2'b10: begin
                wmask_s       = addr[1] ? 4'b1100 : 4'b0011;
                wword_s       = {2{wdata[15:0]}};
                st_align_ok_s = ~addr[0];
            end
            2'b11: begin
                wmask_s       = 4'b1111;
                wword_s       = wdata;
                st_align_ok_s = (addr[1:0] == 2'b00);
            end
            default: begin
                wmask_s       = 4'b0000;
                wword_s       = 32'h0000_0000;
                st_align_ok_s = 1'b1;
            end
        endcase
    end

    // Load size decode. Unlisted SizeLoad codes behave as LW.
    always_comb begin
        ld_byte_s     = 1'b0;
        ld_half_s     = 1'b0;
        ld_align_ok_s = 1'b1;
        case (SizeLoad)
            3'b000, 3'b100: ld_byte_s = 1'b1;
            3'b001, 3'b101: begin
                ld_half_s     = 1'b1;
                ld_align_ok_s = ~addr[0];
            end
            default: ld_align_ok_s = (addr[1:0] == 2'b00);
        endcase
    end

    assign store_fault_s = (MemWrite != 2'b00) &
                           (~st_align_ok_s | ~region_ok_s | cycle_subword_s);
    assign load_fault_s  = ResultSrc & (~ld_align_ok_s | ~region_ok_s);
    assign store_en_s    = (MemWrite != 2'b00) & ~store_fault_s;

    // Load path. The word is read before the edge, so a store to the same
    // word in the same cycle is not visible to the load.
    assign raw_s     = in_ram_s ? mem_r[word_idx_s] : mmio_rd_s;
    assign shifted_s = raw_s >> {addr[1:0], 3'b000};
    assign byte_s    = shifted_s[7:0];
    assign half_s    = addr[1] ? raw_s[31:16] : raw_s[15:0];

    // Extend the selected byte or half. Force 0 when idle or faulting.
    always_comb begin
        rdata = 32'h0000_0000;
        if (!ResultSrc || load_fault_s) begin
            rdata = 32'h0000_0000;
        end else if (ld_byte_s) begin
            rdata = SizeLoad[2] ? {24'h00_0000, byte_s} : {{24{byte_s[7]}}, byte_s};
        end else if (ld_half_s) begin
            rdata = SizeLoad[2] ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
        end else begin
            rdata = raw_s;
        end
    end

    // RAM array: async clear, lane-masked write on legal stores.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (store_en_s && in_ram_s) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_s[b]) begin
                    mem_r[word_idx_s][8*b +: 8] <= wword_s[8*b +: 8];
                end
            end
        end
    end

    // Sticky error flag. A new fault overrides a clear in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_r <= 1'b0;
        end else if (store_fault_s || load_fault_s) begin
            err_r <= 1'b1;
        end else if (err_clr) begin
            err_r <= 1'b0;
        end
    end

    assign err = err_r;

`ifdef DATA_MEM_MMIO_EN
    logic [31:0] cycle_r;
    logic [31:0] gpio_r;
    logic [1:0]  mmio_sel_s;

    assign in_mmio_s       = (addr[31:4] == 28'hFFF_FFF0);
    assign mmio_sel_s      = addr[3:2];
    // CYCLE only accepts whole-word writes.
    assign cycle_subword_s = in_mmio_s & (mmio_sel_s == 2'd0) & (MemWrite != 2'b11);

    // MMIO read mux.
    always_comb begin
        mmio_rd_s = 32'h0000_0000;
        case (mmio_sel_s)
            2'd0:    mmio_rd_s = cycle_r;
            2'd1:    mmio_rd_s = gpio_r;
            default: mmio_rd_s = 32'h0000_0000;
        endcase
    end

    // Free-running cycle counter. A legal SW to CYCLE takes priority over the increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_r <= 32'h0000_0000;
        end else if (store_en_s && in_mmio_s && (mmio_sel_s == 2'd0)) begin
            cycle_r <= 32'h0000_0000;
        end else begin
            cycle_r <= cycle_r + 32'h0000_0001;
        end
    end

    // GPIO register, written lane by lane like a RAM word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_r <= 32'h0000_0000;
        end else if (store_en_s && in_mmio_s && (mmio_sel_s == 2'd1)) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_s[b]) begin
                    gpio_r[8*b +: 8] <= wword_s[8*b +: 8];
                end
            end
        end
    end

    assign gpio_out = gpio_r;
`else
    assign in_mmio_s       = 1'b0;
    assign cycle_subword_s = 1'b0;
    assign mmio_rd_s       = 32'h0000_0000;
    assign gpio_out        = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_data_mem_resp.sv
module tb_data_mem_resp;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [1:0]  MemWrite = 2'b00;
    logic [2:0]  SizeLoad = 3'b000;
    logic        ResultSrc = 1'b0;
    logic        err_clr = 1'b0;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] gpio_out;

    int checks = 0;
    int errors = 0;

`ifdef DATA_MEM_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    // Reference model: byte-addressed memory plus MMIO state.
    logic [7:0]  m_mem [1024];
    logic        m_err;
    logic [31:0] m_gpio;
    logic [31:0] m_cyc;

    data_mem_resp dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .MemWrite(MemWrite), .SizeLoad(SizeLoad), .ResultSrc(ResultSrc),
        .rdata(rdata), .err(err), .err_clr(err_clr), .gpio_out(gpio_out)
    );

    always #5 clk = ~clk;

    function automatic int unsigned st_bytes(input logic [1:0] mw);
        return (mw == 2'b01) ? 1 : (mw == 2'b10) ? 2 : 4;
    endfunction

    function automatic int unsigned ld_bytes(input logic [2:0] sl);
        if (sl == 3'b000 || sl == 3'b100) return 1;
        if (sl == 3'b001 || sl == 3'b101) return 2;
        return 4;
    endfunction

    function automatic bit in_region(input logic [31:0] a);
        return (a < 32'd1024) || (MMIO && a >= 32'hFFFF_FF00 && a <= 32'hFFFF_FF0F);
    endfunction

    function automatic bit st_fault();
        int unsigned n;
        n = st_bytes(MemWrite);
        if (MemWrite == 2'b00) return 1'b0;
        return (addr % n != 0) || !in_region(addr) ||
               (MMIO && addr >= 32'hFFFF_FF00 && addr <= 32'hFFFF_FF03 && n != 4);
    endfunction

    function automatic bit ld_fault();
        int unsigned n;
        n = ld_bytes(SizeLoad);
        if (!ResultSrc) return 1'b0;
        return (addr % n != 0) || !in_region(addr);
    endfunction

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        logic [31:0] off;
        logic [31:0] w;
        if (a < 32'd1024) return m_mem[a];
        off = a - 32'hFFFF_FF00;
        if (off < 4)      w = m_cyc >> (8 * off);
        else if (off < 8) w = m_gpio >> (8 * (off - 4));
        else              w = 32'h0;
        return w[7:0];
    endfunction

    function automatic logic [31:0] model_rdata();
        int unsigned n;
        logic [31:0] v;
        if (!ResultSrc || ld_fault()) return 32'h0;
        n = ld_bytes(SizeLoad);
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | ({24'h0, byte_at(addr + i)} << (8 * i));
        if (n < 4 && !SizeLoad[2] && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic drive(input logic [1:0] mw, input logic [2:0] sl, input logic rs,
                         input logic [31:0] a, input logic [31:0] wd, input logic clr);
        MemWrite = mw; SizeLoad = sl; ResultSrc = rs; addr = a; wdata = wd; err_clr = clr;
        #2;
    endtask

    task automatic idle();
        drive(2'b00, 3'b010, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    // One clock edge: advance the model using the inputs present before it.
    task automatic step();
        bit f, cyc_clr;
        logic [31:0] a, off;
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < 1024; i++) m_mem[i] = 8'h00;
            m_err = 1'b0; m_gpio = 32'h0; m_cyc = 32'h0;
        end else begin
            f = st_fault() | ld_fault();
            cyc_clr = 1'b0;
            if (MemWrite != 2'b00 && !st_fault()) begin
                for (int i = 0; i < st_bytes(MemWrite); i++) begin
                    a = addr + i;
                    if (a < 32'd1024) m_mem[a] = wdata[8*i +: 8];
                    else begin
                        off = a - 32'hFFFF_FF00;
                        if (off < 4) cyc_clr = 1'b1;
                        else if (off < 8) m_gpio[8*(off-4) +: 8] = wdata[8*i +: 8];
                    end
                end
            end
            m_cyc = cyc_clr ? 32'h0 : m_cyc + 32'h1;
            m_err = f ? 1'b1 : (err_clr ? 1'b0 : m_err);
        end
        #1;
    endtask

    task automatic test_reset();
        step(); step();
        reset = 1'b1;
        drive(2'b11, 3'b010, 1'b0, 32'h40, 32'hDEAD_BEEF, 1'b0);
        reset = 1'b0;
        step(); step();
        idle();
        reset = 1'b1;
        #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want %h", rdata, 32'h0); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (gpio_out !== 32'h0) begin errors++; $display("FAIL reset_gpio: got %h want 0", gpio_out); end
        step();
        drive(2'b00, 3'b010, 1'b1, 32'h40, 32'h0, 1'b0);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_word40: got %h want %h", rdata, 32'h0); end
        step();
    endtask

    task automatic test_load_ext();
        logic [31:0] exp [5];
        logic [2:0]  sl [5];
        logic [31:0] ad [5];
        exp = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_8000, 32'h0000_8000, 32'h8000_80F0};
        sl  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        ad  = '{32'h10, 32'h10, 32'h12, 32'h12, 32'h10};
        drive(2'b11, 3'b010, 1'b0, 32'h10, 32'h8000_80F0, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(2'b00, sl[i], 1'b1, ad[i], 32'h0, 1'b0);
            checks++;
            if (rdata !== exp[i]) begin errors++; $display("FAIL load_ext_%0d: got %h want %h", i, rdata, exp[i]); end
            step();
        end
    endtask

    task automatic test_lanes();
        drive(2'b11, 3'b010, 1'b0, 32'h20, 32'h1122_3344, 1'b0); step();
        drive(2'b01, 3'b010, 1'b0, 32'h21, 32'hFFFF_FFAA, 1'b0); step();
        drive(2'b10, 3'b010, 1'b0, 32'h22, 32'h1234_BEEF, 1'b0); step();
        drive(2'b00, 3'b010, 1'b1, 32'h20, 32'h0, 1'b0);
        checks++; if (rdata !== 32'hBEEF_AA44) begin errors++; $display("FAIL lanes_merge: got %h want %h", rdata, 32'hBEEF_AA44); end
        step();
        // Store and load on the same word in one cycle: load sees old contents.
        drive(2'b11, 3'b010, 1'b1, 32'h20, 32'h5555_AAAA, 1'b0);
        checks++; if (rdata !== 32'hBEEF_AA44) begin errors++; $display("FAIL rdw_old: got %h want %h", rdata, 32'hBEEF_AA44); end
        step();
        drive(2'b00, 3'b010, 1'b1, 32'h20, 32'h0, 1'b0);
        checks++; if (rdata !== 32'h5555_AAAA) begin errors++; $display("FAIL rdw_new: got %h want %h", rdata, 32'h5555_AAAA); end
        step();
    endtask

    task automatic test_misalign_err();
        drive(2'b11, 3'b010, 1'b0, 32'h30, 32'h1234_5678, 1'b0); step();
        drive(2'b10, 3'b010, 1'b0, 32'h31, 32'h0000_FFFF, 1'b0); step();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL sh_misalign_err: got %b want 1", err); end
        drive(2'b00, 3'b010, 1'b1, 32'h30, 32'h0, 1'b0);
        checks++; if (rdata !== 32'h1234_5678) begin errors++; $display("FAIL sh_misalign_keep: got %h want %h", rdata, 32'h1234_5678); end
        step();
        drive(2'b10, 3'b010, 1'b0, 32'h31, 32'h0000_FFFF, 1'b1); step();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL clr_vs_fault: got %b want 1", err); end
        drive(2'b00, 3'b010, 1'b0, 32'h0, 32'h0, 1'b1); step();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clr: got %b want 0", err); end
    endtask

    task automatic test_out_of_range();
        drive(2'b00, 3'b010, 1'b1, 32'h400, 32'h0, 1'b0);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL oor_rdata: got %h want 0", rdata); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL oor_err_early: got %b want 0", err); end
        step();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_err: got %b want 1", err); end
        drive(2'b00, 3'b010, 1'b0, 32'h0, 32'h0, 1'b1); step();
        idle(); step();
    endtask

    task automatic test_mmio();
`ifdef DATA_MEM_MMIO_EN
        logic [31:0] c1, c2;
        drive(2'b00, 3'b010, 1'b1, 32'hFFFF_FF00, 32'h0, 1'b0);
        c1 = rdata;
        checks++; if (c1 !== m_cyc) begin errors++; $display("FAIL cycle_val: got %h want %h", c1, m_cyc); end
        step();
        for (int i = 0; i < 4; i++) begin idle(); step(); end
        drive(2'b00, 3'b010, 1'b1, 32'hFFFF_FF00, 32'h0, 1'b0);
        c2 = rdata;
        checks++; if (c2 - c1 !== 32'd5) begin errors++; $display("FAIL cycle_diff: got %0d want 5", c2 - c1); end
        step();
        drive(2'b11, 3'b010, 1'b0, 32'hFFFF_FF00, $urandom, 1'b0); step();
        idle(); step();
        drive(2'b00, 3'b010, 1'b1, 32'hFFFF_FF00, 32'h0, 1'b0);
        checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL cycle_sw: got %h want 1", rdata); end
        step();
        drive(2'b01, 3'b010, 1'b0, 32'hFFFF_FF05, 32'h0000_005A, 1'b0); step();
        checks++; if (gpio_out !== 32'h0000_5A00) begin errors++; $display("FAIL gpio_sb: got %h want %h", gpio_out, 32'h0000_5A00); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL gpio_sb_err: got %b want 0", err); end
        drive(2'b01, 3'b010, 1'b0, 32'hFFFF_FF01, 32'h0000_0077, 1'b0); step();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL cycle_sb_fault: got %b want 1", err); end
        drive(2'b00, 3'b010, 1'b0, 32'h0, 32'h0, 1'b1); step();
`else
        drive(2'b01, 3'b010, 1'b0, 32'hFFFF_FF05, 32'h0000_005A, 1'b0); step();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL nommio_err: got %b want 1", err); end
        checks++; if (gpio_out !== 32'h0) begin errors++; $display("FAIL nommio_gpio: got %h want 0", gpio_out); end
        drive(2'b00, 3'b010, 1'b0, 32'h0, 32'h0, 1'b1); step();
`endif
    endtask

    task automatic test_random();
        logic [31:0] a, exp;
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'd1016 + $urandom_range(0, 15);
                1:       a = $urandom;
                default: a = $urandom_range(0, 63);
            endcase
            drive($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 1), a,
                  $urandom, ($urandom_range(0, 7) == 0));
            exp = model_rdata();
            checks++;
            if (rdata !== exp) begin errors++; $display("FAIL rand_rdata it=%0d addr=%h: got %h want %h", it, addr, rdata, exp); end
            step();
            checks++;
            if (err !== m_err) begin errors++; $display("FAIL rand_err it=%0d: got %b want %b", it, err, m_err); end
        end
        for (int w = 0; w < 16; w++) begin
            drive(2'b00, 3'b010, 1'b1, 32'(w * 4), 32'h0, 1'b0);
            exp = model_rdata();
            checks++;
            if (rdata !== exp) begin errors++; $display("FAIL rand_final word=%0d: got %h want %h", w, rdata, exp); end
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) m_mem[i] = 8'h00;
        m_err = 1'b0; m_gpio = 32'h0; m_cyc = 32'h0;
        test_reset();
        test_load_ext();
        test_lanes();
        test_misalign_err();
        test_out_of_range();
        test_mmio();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
